pdp_instr_decode: RTL and testbench



---
 rtl/pdp_instr_decode.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_pdp_instr_decode.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp_instr_decode.sv
// PDP-8 instruction fetch/decode stage.
// Fetches one 12-bit word at a time and decodes it into one-hot opcode busses
// for the exec unit. Only one instruction is in flight at any time.
// Optional performance counters are built when IFD_PERF_CNT_EN is defined.

`ifndef START_ADDRESS
`define START_ADDRESS 12'o200
`endif
`ifndef NOP
`define NOP     12'o7000
`endif
`ifndef IAC
`define IAC     12'o7001
`endif
`ifndef RAL
`define RAL     12'o7004
`endif
`ifndef RTL
`define RTL     12'o7006
`endif
`ifndef RAR
`define RAR     12'o7010
`endif
`ifndef RTR
`define RTR     12'o7012
`endif
`ifndef CML
`define CML     12'o7020
`endif
`ifndef CMA
`define CMA     12'o7040
`endif
`ifndef CIA
`define CIA     12'o7041
`endif
`ifndef CLL
`define CLL     12'o7100
`endif
`ifndef CLA1
`define CLA1    12'o7200
`endif
`ifndef CLA_CLL
`define CLA_CLL 12'o7300
`endif
`ifndef HLT
`define HLT     12'o7402
`endif
`ifndef OSR
`define OSR     12'o7404
`endif
`ifndef SKP
`define SKP     12'o7410
`endif
`ifndef SNL
`define SNL     12'o7420
`endif
`ifndef SZL
`define SZL     12'o7430
`endif
`ifndef SZA
`define SZA     12'o7440
`endif
`ifndef SNA
`define SNA     12'o7450
`endif
`ifndef SMA
`define SMA     12'o7500
`endif
`ifndef SPA
`define SPA     12'o7510
`endif
`ifndef CLA2
`define CLA2    12'o7600
`endif

package pdp_instr_decode_pkg;

    typedef struct packed {
        logic       and_op;
        logic       tad_op;
        logic       isz_op;
        logic       dca_op;
        logic       jms_op;
        logic       jmp_op;
        logic [8:0] mem_inst_addr;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic nop;
        logic iac;
        logic ral;
        logic rtl;
        logic rar;
        logic rtr;
        logic cml;
        logic cma;
        logic cia;
        logic cll;
        logic cla1;
        logic cla_cll;
        logic hlt;
        logic osr;
        logic skp;
        logic snl;
        logic szl;
        logic sza;
        logic sna;
        logic sma;
        logic spa;
        logic cla2;
    } pdp_op7_opcode_s;

endpackage

module pdp_instr_decode
    import pdp_instr_decode_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    DATA_WIDTH  = 12,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = `START_ADDRESS,
    parameter int                    MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ifu_rd_req,
    output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    input  logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output pdp_mem_opcode_s       pdp_mem_opcode,
    output pdp_op7_opcode_s       pdp_op7_opcode,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] PC_value,
    output logic                  halted,
    output logic                  decode_err
`ifdef IFD_PERF_CNT_EN
    ,
    output logic [31:0]           instr_count,
    output logic [31:0]           stall_cycles
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_EXEC    = 3'd4;
    localparam logic [2:0] S_HALTED  = 3'd5;

    localparam int              LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

    logic [2:0]       state;
    logic [LAT_W-1:0] wait_cnt;
    pdp_mem_opcode_s  dec_mem;
    pdp_op7_opcode_s  dec_op7;
    logic             dec_err;

    // The request is a pure function of the state, so it is high for exactly the FETCH cycle.
    assign ifu_rd_req = (state == S_FETCH);

    // Decode the raw memory word; IOT and unlisted operate words are errors.
    always_comb begin
        dec_mem = '0;
        dec_op7 = '0;
        dec_err = 1'b0;
        case (ifu_rd_data[11:9])
            3'd0: dec_mem.and_op = 1'b1;
            3'd1: dec_mem.tad_op = 1'b1;
            3'd2: dec_mem.isz_op = 1'b1;
            3'd3: dec_mem.dca_op = 1'b1;
            3'd4: dec_mem.jms_op = 1'b1;
            3'd5: dec_mem.jmp_op = 1'b1;
            3'd7: begin
                case (ifu_rd_data[11:0])
                    `NOP:     dec_op7.nop     = 1'b1;
                    `IAC:     dec_op7.iac     = 1'b1;
                    `RAL:     dec_op7.ral     = 1'b1;
                    `RTL:     dec_op7.rtl     = 1'b1;
                    `RAR:     dec_op7.rar     = 1'b1;
                    `RTR:     dec_op7.rtr     = 1'b1;
                    `CML:     dec_op7.cml     = 1'b1;
                    `CMA:     dec_op7.cma     = 1'b1;
                    `CIA:     dec_op7.cia     = 1'b1;
                    `CLL:     dec_op7.cll     = 1'b1;
                    `CLA1:    dec_op7.cla1    = 1'b1;
                    `CLA_CLL: dec_op7.cla_cll = 1'b1;
                    `HLT:     dec_op7.hlt     = 1'b1;
                    `OSR:     dec_op7.osr     = 1'b1;
                    `SKP:     dec_op7.skp     = 1'b1;
                    `SNL:     dec_op7.snl     = 1'b1;
                    `SZL:     dec_op7.szl     = 1'b1;
                    `SZA:     dec_op7.sza     = 1'b1;
                    `SNA:     dec_op7.sna     = 1'b1;
                    `SMA:     dec_op7.sma     = 1'b1;
                    `SPA:     dec_op7.spa     = 1'b1;
                    `CLA2:    dec_op7.cla2    = 1'b1;
                    default:  dec_err         = 1'b1;
                endcase
            end
            default: dec_err = 1'b1;
        endcase
        if (ifu_rd_data[11:9] < 3'd6) begin
            dec_mem.mem_inst_addr = ifu_rd_data[8:0];
        end
    end

    // Fetch/decode sequencer: fetch, wait out the memory latency, present flags, hold until exec finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            wait_cnt       <= '0;
            ifu_rd_addr    <= '0;
            base_addr      <= '0;
            pdp_mem_opcode <= '0;
            pdp_op7_opcode <= '0;
            halted         <= 1'b0;
            decode_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    base_addr   <= START_ADDR;
                    ifu_rd_addr <= START_ADDR;
                    state       <= S_FETCH;
                end
                S_FETCH: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == LAT_LAST) begin
                        if (dec_err) begin
                            decode_err <= 1'b1;
                            halted     <= 1'b1;
                            state      <= S_HALTED;
                        end else begin
                            pdp_mem_opcode <= dec_mem;
                            pdp_op7_opcode <= dec_op7;
                            state          <= S_PRESENT;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (stall) begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        pdp_mem_opcode <= '0;
                        pdp_op7_opcode <= '0;
                        if (pdp_op7_opcode.hlt) begin
                            halted <= 1'b1;
                            state  <= S_HALTED;
                        end else begin
                            ifu_rd_addr <= PC_value;
                            state       <= S_FETCH;
                        end
                    end
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_IDLE;
            endcase
        end
    end

`ifdef IFD_PERF_CNT_EN
    // Saturating counters of accepted instructions and of cycles spent waiting on the exec unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count  <= '0;
            stall_cycles <= '0;
        end else begin
            if (state == S_PRESENT && stall && instr_count != 32'hFFFF_FFFF) begin
                instr_count <= instr_count + 32'd1;
            end
            if (state == S_EXEC && stall_cycles != 32'hFFFF_FFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pdp_instr_decode.sv
// Self-checking bench for pdp_instr_decode (START_ADDRESS=o200, MEM_LATENCY=1).
// Counter checks are compiled in when IFD_PERF_CNT_EN is defined.
module tb_pdp_instr_decode;
    import pdp_instr_decode_pkg::*;

    localparam int MEM_LAT = 1;

    // Operate-group words in flag order (first entry is the most significant flag bit).
    localparam logic [11:0] OP7_TAB [22] = '{
        12'o7000, 12'o7001, 12'o7004, 12'o7006, 12'o7010, 12'o7012, 12'o7020, 12'o7040,
        12'o7041, 12'o7100, 12'o7200, 12'o7300, 12'o7402, 12'o7404, 12'o7410, 12'o7420,
        12'o7430, 12'o7440, 12'o7450, 12'o7500, 12'o7510, 12'o7600};
    localparam int HLT_IDX = 12;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ifu_rd_req;
    logic [11:0]      ifu_rd_addr;
    logic [11:0]      ifu_rd_data = '0;
    logic [11:0]      base_addr;
    pdp_mem_opcode_s  mem_op;
    pdp_op7_opcode_s  op7_op;
    logic             stall = 1'b0;
    logic [11:0]      PC_value = '0;
    logic             halted;
    logic             decode_err;
`ifdef IFD_PERF_CNT_EN
    logic [31:0]      instr_count;
    logic [31:0]      stall_cycles;
`endif

    logic [11:0] mem [4096];
    logic [11:0] cur_pc;
    int          checks = 0;
    int          failures = 0;
    int          seen_cnt [28];

    pdp_instr_decode dut (
        .clk            (clk),
        .reset          (reset),
        .ifu_rd_req     (ifu_rd_req),
        .ifu_rd_addr    (ifu_rd_addr),
        .ifu_rd_data    (ifu_rd_data),
        .base_addr      (base_addr),
        .pdp_mem_opcode (mem_op),
        .pdp_op7_opcode (op7_op),
        .stall          (stall),
        .PC_value       (PC_value),
        .halted         (halted),
        .decode_err     (decode_err)
`ifdef IFD_PERF_CNT_EN
        ,
        .instr_count    (instr_count),
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: data for a request is valid during the cycle after it; junk otherwise.
    always @(posedge clk) begin
        if (ifu_rd_req === 1'b1) ifu_rd_data <= mem[ifu_rd_addr];
        else                     ifu_rd_data <= 12'($urandom);
    end

    // Reference decode: opcodes 0-5 are memory ops, 7 must match the operate table, else error.
    function automatic void model(input logic [11:0] w, output logic [14:0] m,
                                  output logic [21:0] o, output bit err);
        int opc;
        m = '0; o = '0; err = 1'b1;
        opc = int'(w[11:9]);
        if (opc < 6) begin
            m[14 - opc] = 1'b1;
            m[8:0] = w[8:0];
            err = 1'b0;
        end else if (opc == 7) begin
            for (int i = 0; i < 22; i++) begin
                if (OP7_TAB[i] == w) begin
                    o[21 - i] = 1'b1;
                    err = 1'b0;
                end
            end
        end
    endfunction

    function automatic logic [11:0] random_valid_word();
        int idx;
        if ($urandom_range(0, 1) == 0) return {3'($urandom_range(0, 5)), 9'($urandom)};
        do idx = $urandom_range(0, 21); while (idx == HLT_IDX);
        return OP7_TAB[idx];
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        stall = 1'b0;
        PC_value = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cur_pc = 12'o200;
    endtask

    // Run one instruction at cur_pc: fetch, latency, present, stall handshake, next PC.
    task automatic do_instr(input logic [11:0] word, input int k, input int d,
                            input bit pre, input logic [11:0] next_pc);
        logic [14:0] exp_m;
        logic [21:0] exp_o;
        bit          exp_err;
        bit          found;
        model(word, exp_m, exp_o, exp_err);
        mem[cur_pc] = word;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ifu_rd_req === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL fetch_timeout: no ifu_rd_req within 20 cycles, expected addr %o", cur_pc);
            return;
        end
        checks++;
        if (ifu_rd_addr !== cur_pc) begin
            failures++;
            $display("[TB] FAIL fetch_addr: got %o expected %o", ifu_rd_addr, cur_pc);
        end
        checks++;
        if (base_addr !== 12'o200) begin
            failures++;
            $display("[TB] FAIL base_addr: got %o expected 200", base_addr);
        end
        checks++;
        if ({mem_op, op7_op} !== 37'd0) begin
            failures++;
            $display("[TB] FAIL flags_during_req: got %h expected 0", {mem_op, op7_op});
        end
        if (pre) stall = 1'b1;
        repeat (MEM_LAT) begin
            @(negedge clk);
            checks++;
            if (ifu_rd_req !== 1'b0 || {mem_op, op7_op} !== 37'd0 || ifu_rd_addr !== cur_pc) begin
                failures++;
                $display("[TB] FAIL wait_state: req=%b flags=%h addr=%o expected req=0 flags=0 addr=%o",
                         ifu_rd_req, {mem_op, op7_op}, ifu_rd_addr, cur_pc);
            end
        end
        @(negedge clk);
        checks++;
        if (mem_op !== exp_m) begin
            failures++;
            $display("[TB] FAIL mem_decode word=%o: got %h expected %h", word, mem_op, exp_m);
        end
        checks++;
        if (op7_op !== exp_o) begin
            failures++;
            $display("[TB] FAIL op7_decode word=%o: got %h expected %h", word, op7_op, exp_o);
        end
        for (int b = 0; b < 22; b++) if (op7_op[21 - b] === 1'b1) seen_cnt[b]++;
        for (int j = 0; j < 6; j++) if (mem_op[14 - j] === 1'b1) seen_cnt[22 + j]++;
        if (!pre) begin
            repeat (d) begin
                @(negedge clk);
                checks++;
                if ({mem_op, op7_op} !== {exp_m, exp_o} || ifu_rd_req !== 1'b0 || halted !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL present_hold: flags=%h req=%b halted=%b expected %h 0 0",
                             {mem_op, op7_op}, ifu_rd_req, halted, {exp_m, exp_o});
                end
            end
            stall = 1'b1;
        end
        repeat (k) begin
            @(negedge clk);
            checks++;
            if ({mem_op, op7_op} !== {exp_m, exp_o} || ifu_rd_req !== 1'b0 || halted !== 1'b0) begin
                failures++;
                $display("[TB] FAIL exec_hold: flags=%h req=%b halted=%b expected %h 0 0",
                         {mem_op, op7_op}, ifu_rd_req, halted, {exp_m, exp_o});
            end
        end
        stall = 1'b0;
        PC_value = next_pc;
        cur_pc = next_pc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ifu_rd_req, ifu_rd_addr, base_addr, mem_op, op7_op, halted, decode_err} !== 64'd0) begin
            failures++;
            $display("[TB] FAIL reset_values: req=%b addr=%o base=%o flags=%h halted=%b err=%b expected all 0",
                     ifu_rd_req, ifu_rd_addr, base_addr, {mem_op, op7_op}, halted, decode_err);
        end
        apply_reset();
        @(negedge clk);
        checks++;
        if (base_addr !== 12'o200) begin
            failures++;
            $display("[TB] FAIL base_after_release: got %o expected 200", base_addr);
        end
    endtask

    task automatic test_first_fetch_and_cia();
        apply_reset();
        do_instr(12'o1234, 2, 0, 1'b0, 12'o300);
        do_instr(12'o7041, 3, 1, 1'b0, 12'o201);
        do_instr(12'o5377, 1, 0, 1'b1, 12'o7777);
        do_instr(12'o7001, 2, 0, 1'b0, 12'o0);
        do_instr(12'o0000, 1, 0, 1'b0, 12'o400);
    endtask

    task automatic test_random_program();
        logic [11:0] nxt;
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            nxt = ($urandom_range(0, 9) == 0) ? 12'o7777 : 12'($urandom);
            do_instr(random_valid_word(), $urandom_range(1, 4), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), nxt);
        end
    endtask

    task automatic test_sweep_and_halt();
        int bad;
        int reqs;
        for (int i = 0; i < 28; i++) seen_cnt[i] = 0;
        apply_reset();
        for (int i = 0; i < 22; i++) begin
            if (i != HLT_IDX) do_instr(OP7_TAB[i], $urandom_range(1, 3), 0, 1'b0, cur_pc + 12'd1);
        end
        for (int j = 0; j < 6; j++) begin
            do_instr({3'(j), 9'($urandom)}, 1, 0, 1'b0, cur_pc + 12'd1);
        end
        do_instr(12'o7402, 2, 0, 1'b0, 12'o1000);
        bad = 0;
        for (int i = 0; i < 28; i++) if (seen_cnt[i] != 1) bad++;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL sweep_coverage: %0d flags not seen exactly once, expected 0", bad);
        end
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || decode_err !== 1'b0 || {mem_op, op7_op} !== 37'd0) begin
            failures++;
            $display("[TB] FAIL hlt_retire: halted=%b err=%b flags=%h expected 1 0 0",
                     halted, decode_err, {mem_op, op7_op});
        end
        reqs = 0;
        repeat (30) begin
            @(negedge clk);
            if (ifu_rd_req === 1'b1) reqs++;
        end
        checks++;
        if (reqs !== 0) begin
            failures++;
            $display("[TB] FAIL hlt_no_fetch: got %0d requests expected 0", reqs);
        end
    endtask

    task automatic test_decode_error(input logic [11:0] word);
        bit found;
        int reqs;
        apply_reset();
        mem[12'o200] = word;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ifu_rd_req === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL err_fetch_timeout: no ifu_rd_req within 20 cycles");
            return;
        end
        repeat (MEM_LAT + 1) @(negedge clk);
        checks++;
        if (halted !== 1'b1 || decode_err !== 1'b1 || {mem_op, op7_op} !== 37'd0) begin
            failures++;
            $display("[TB] FAIL decode_error word=%o: halted=%b err=%b flags=%h expected 1 1 0",
                     word, halted, decode_err, {mem_op, op7_op});
        end
        reqs = 0;
        repeat (100) begin
            @(negedge clk);
            if (ifu_rd_req === 1'b1) reqs++;
        end
        checks++;
        if (reqs !== 0 || halted !== 1'b1 || decode_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL err_no_fetch word=%o: reqs=%0d halted=%b err=%b expected 0 1 1",
                     word, reqs, halted, decode_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit found;
        apply_reset();
        do_instr(12'o3123, 1, 0, 1'b0, 12'o555);
        mem[12'o555] = 12'o7041;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ifu_rd_req === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL midwait_fetch_timeout: no ifu_rd_req within 20 cycles");
            return;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({ifu_rd_req, ifu_rd_addr, base_addr, mem_op, op7_op, halted, decode_err} !== 64'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: req=%b addr=%o base=%o flags=%h halted=%b err=%b expected all 0",
                     ifu_rd_req, ifu_rd_addr, base_addr, {mem_op, op7_op}, halted, decode_err);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cur_pc = 12'o200;
        do_instr(12'o2777, 1, 0, 1'b0, 12'o201);
    endtask

`ifdef IFD_PERF_CNT_EN
    task automatic test_perf_counters();
        apply_reset();
        for (int n = 0; n < 5; n++) do_instr(random_valid_word(), 4, 0, 1'b0, 12'($urandom));
        @(negedge clk);
        checks++;
        if (instr_count !== 32'd5) begin
            failures++;
            $display("[TB] FAIL instr_count: got %0d expected 5", instr_count);
        end
        checks++;
        if (stall_cycles !== 32'd20) begin
            failures++;
            $display("[TB] FAIL stall_cycles: got %0d expected 20", stall_cycles);
        end
    endtask
`endif

    initial begin
        logic [11:0] w;
        bit          e;
        logic [14:0] dm;
        logic [21:0] dop;
        for (int i = 0; i < 4096; i++) mem[i] = 12'o6000;
        cur_pc = 12'o200;
        test_reset();
        test_first_fetch_and_cia();
        test_random_program();
        test_sweep_and_halt();
        test_decode_error(12'o6001);
        test_decode_error(12'o7777);
        test_decode_error({3'o6, 9'($urandom)});
        do begin
            w = {3'o7, 9'($urandom)};
            model(w, dm, dop, e);
        end while (!e);
        test_decode_error(w);
        test_reset_mid_wait();
`ifdef IFD_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
